// File: rtl/seq_slice_comparator.sv
// Sequential MSB-first magnitude comparator, one SLICE-bit slice per clock.
// Signed or unsigned operands, start/busy/done handshake, optional early exit.
module seq_slice_comparator #(
    parameter int WIDTH      = 16,
    parameter int SLICE      = 4,
    parameter int EARLY_EXIT = 1,
    localparam int NSLICE    = WIDTH / SLICE,
    localparam int CW        = $clog2(NSLICE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             greater,
    output logic             less,
    output logic [CW-1:0]    cycles
);

    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] TOP_IDX = IW'(NSLICE - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CMP  = 1'b1;

    if ((WIDTH % SLICE) != 0 || NSLICE < 1) begin : g_bad_params
        $error("seq_slice_comparator: WIDTH must be a non-zero multiple of SLICE");
    end

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic             rec_q, rec_d, rec_gt_q, rec_gt_d;

    logic [SLICE-1:0] sa, sb;
    logic             diff, sgt;

    always_comb begin
        sa = '0;
        sb = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IW'(i)) begin
                sa = a_q[i*SLICE +: SLICE];
                sb = b_q[i*SLICE +: SLICE];
            end
        end
        // Flipping the sign bit maps two's complement onto unsigned order.
        if (sgn_q && idx_q == TOP_IDX) begin
            sa[SLICE-1] = ~sa[SLICE-1];
            sb[SLICE-1] = ~sb[SLICE-1];
        end
        diff = (sa != sb);
        sgt  = (sa > sb);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sgn_d    = sgn_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        eq_d     = eq_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        cyc_d    = cyc_q;
        rec_d    = rec_q;
        rec_gt_d = rec_gt_q;
        if (!en) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            eq_d    = 1'b0;
            gt_d    = 1'b0;
            lt_d    = 1'b0;
            rec_d   = 1'b0;
        end else if (state_q == IDLE) begin
            if (start) begin
                state_d = CMP;
                a_d     = a;
                b_d     = b;
                sgn_d   = signed_mode;
                idx_d   = TOP_IDX;
                busy_d  = 1'b1;
                eq_d    = 1'b0;
                gt_d    = 1'b0;
                lt_d    = 1'b0;
                cyc_d   = '0;
                rec_d   = 1'b0;
            end
        end else begin
            cyc_d = cyc_q + CW'(1);
            if (diff && EARLY_EXIT != 0) begin
                gt_d    = sgt;
                lt_d    = ~sgt;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end else if (idx_q == '0) begin
                if (rec_q) begin
                    gt_d = rec_gt_q;
                    lt_d = ~rec_gt_q;
                end else if (diff) begin
                    gt_d = sgt;
                    lt_d = ~sgt;
                end else begin
                    eq_d = 1'b1;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end else begin
                if (diff && !rec_q) begin
                    rec_d    = 1'b1;
                    rec_gt_d = sgt;
                end
                idx_d = idx_q - IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            cyc_q    <= '0;
            rec_q    <= 1'b0;
            rec_gt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sgn_q    <= sgn_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            cyc_q    <= cyc_d;
            rec_q    <= rec_d;
            rec_gt_q <= rec_gt_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign equal   = eq_q;
    assign greater = gt_q;
    assign less    = lt_q;
    assign cycles  = cyc_q;

endmodule

// File: tb/tb_seq_slice_comparator.sv
// Directed bench: early-exit, fixed-latency and single-slice comparators
// driven from shared stimulus.
module tb_seq_slice_comparator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        start = 1'b0;
    logic        sm = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic busy_e, done_e, eq_e, gt_e, lt_e;
    logic [2:0] cyc_e;
    logic busy_f, done_f, eq_f, gt_f, lt_f;
    logic [2:0] cyc_f;
    logic busy_s, done_s, eq_s, gt_s, lt_s;
    logic [0:0] cyc_s;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seq_slice_comparator #(.WIDTH(16), .SLICE(4), .EARLY_EXIT(1)) dut_e (
        .clk(clk), .rst(rst), .en(en), .start(start), .signed_mode(sm),
        .a(a), .b(b), .busy(busy_e), .done(done_e), .equal(eq_e),
        .greater(gt_e), .less(lt_e), .cycles(cyc_e)
    );

    seq_slice_comparator #(.WIDTH(16), .SLICE(4), .EARLY_EXIT(0)) dut_f (
        .clk(clk), .rst(rst), .en(en), .start(start), .signed_mode(sm),
        .a(a), .b(b), .busy(busy_f), .done(done_f), .equal(eq_f),
        .greater(gt_f), .less(lt_f), .cycles(cyc_f)
    );

    seq_slice_comparator #(.WIDTH(4), .SLICE(4), .EARLY_EXIT(1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .start(start), .signed_mode(sm),
        .a(a[3:0]), .b(b[3:0]), .busy(busy_s), .done(done_s), .equal(eq_s),
        .greater(gt_s), .less(lt_s), .cycles(cyc_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmp(input logic [15:0] av, input logic [15:0] bv,
                             input logic s);
        a = av;
        b = bv;
        sm = s;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({busy_e, done_e, eq_e, gt_e, lt_e, cyc_e} !== 8'h00) begin
            bad++;
            $display("FAIL reset_e got=%b want=0",
                     {busy_e, done_e, eq_e, gt_e, lt_e, cyc_e});
        end
        total++;
        if ({busy_s, done_s, eq_s, gt_s, lt_s, cyc_s} !== 6'h00) begin
            bad++;
            $display("FAIL reset_s got=%b want=0",
                     {busy_s, done_s, eq_s, gt_s, lt_s, cyc_s});
        end
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
        step();
    endtask

    task automatic test_equal();
        start_cmp(16'h1234, 16'h1234, 1'b0);
        total++;
        if ({busy_e, done_e} !== 2'b10) begin
            bad++;
            $display("FAIL eq_accept busy/done got=%b want=10", {busy_e, done_e});
        end
        step(); step(); step();
        total++;
        if ({busy_e, done_e, cyc_e} !== 5'b10_011) begin
            bad++;
            $display("FAIL eq_edge3 busy/done/cyc got=%b want=10011",
                     {busy_e, done_e, cyc_e});
        end
        step();
        total++;
        if ({busy_e, done_e, eq_e, gt_e, lt_e, cyc_e} !== 8'b01100_100) begin
            bad++;
            $display("FAIL eq_done_e got=%b want=01100100",
                     {busy_e, done_e, eq_e, gt_e, lt_e, cyc_e});
        end
        total++;
        if ({busy_f, done_f, eq_f, gt_f, lt_f, cyc_f} !== 8'b01100_100) begin
            bad++;
            $display("FAIL eq_done_f got=%b want=01100100",
                     {busy_f, done_f, eq_f, gt_f, lt_f, cyc_f});
        end
        step();
        total++;
        if ({done_e, eq_e, cyc_e} !== 5'b01_100) begin
            bad++;
            $display("FAIL eq_hold got=%b want=01100", {done_e, eq_e, cyc_e});
        end
    endtask

    task automatic test_early_exit();
        start_cmp(16'h9000, 16'h1000, 1'b0);
        step();
        total++;
        if ({done_e, eq_e, gt_e, lt_e, cyc_e} !== 7'b1010_001) begin
            bad++;
            $display("FAIL early_u got=%b want=1010001",
                     {done_e, eq_e, gt_e, lt_e, cyc_e});
        end
        total++;
        if ({busy_f, done_f, gt_f} !== 3'b100) begin
            bad++;
            $display("FAIL fixed_u_edge1 got=%b want=100", {busy_f, done_f, gt_f});
        end
        step(); step(); step();
        total++;
        if ({done_f, eq_f, gt_f, lt_f, cyc_f} !== 7'b1010_100) begin
            bad++;
            $display("FAIL fixed_u_edge4 got=%b want=1010100",
                     {done_f, eq_f, gt_f, lt_f, cyc_f});
        end
        total++;
        if ({done_e, gt_e} !== 2'b01) begin
            bad++;
            $display("FAIL early_u_hold got=%b want=01", {done_e, gt_e});
        end
        step();
        start_cmp(16'h9000, 16'h1000, 1'b1);
        step();
        total++;
        if ({done_e, eq_e, gt_e, lt_e, cyc_e} !== 7'b1001_001) begin
            bad++;
            $display("FAIL early_s got=%b want=1001001",
                     {done_e, eq_e, gt_e, lt_e, cyc_e});
        end
        step(); step(); step();
        total++;
        if ({done_f, eq_f, gt_f, lt_f, cyc_f} !== 7'b1001_100) begin
            bad++;
            $display("FAIL fixed_s got=%b want=1001100",
                     {done_f, eq_f, gt_f, lt_f, cyc_f});
        end
        step();
    endtask

    task automatic test_late_diff();
        // Nibbles 0,0,F,F vs 0,1,0,0: the second slice decides.
        start_cmp(16'h00FF, 16'h0100, 1'b0);
        step();
        total++;
        if (done_e !== 1'b0) begin
            bad++;
            $display("FAIL late_edge1 done got=%b want=0", done_e);
        end
        step();
        total++;
        if ({done_e, eq_e, gt_e, lt_e, cyc_e} !== 7'b1001_010) begin
            bad++;
            $display("FAIL late_e got=%b want=1001010",
                     {done_e, eq_e, gt_e, lt_e, cyc_e});
        end
        step(); step();
        total++;
        if ({done_f, eq_f, gt_f, lt_f, cyc_f} !== 7'b1001_100) begin
            bad++;
            $display("FAIL late_f got=%b want=1001100",
                     {done_f, eq_f, gt_f, lt_f, cyc_f});
        end
        step();
    endtask

    task automatic test_abort_busy_start();
        start_cmp(16'h1234, 16'h1234, 1'b0);
        step(); step();
        en = 1'b0;
        step();
        total++;
        if ({busy_e, done_e, eq_e, gt_e, lt_e, cyc_e} !== 8'b00000_010) begin
            bad++;
            $display("FAIL abort_e got=%b want=00000010",
                     {busy_e, done_e, eq_e, gt_e, lt_e, cyc_e});
        end
        total++;
        if ({busy_f, done_f, eq_f, gt_f, lt_f} !== 5'b00000) begin
            bad++;
            $display("FAIL abort_f got=%b want=00000",
                     {busy_f, done_f, eq_f, gt_f, lt_f});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({done_e, done_f, busy_e} !== 3'b000) begin
                bad++;
                $display("FAIL abort_nodone[%0d] got=%b want=000", i,
                         {done_e, done_f, busy_e});
            end
        end
        en = 1'b1;
        start_cmp(16'h1234, 16'h1234, 1'b0);
        step();
        a = 16'hFFFF;
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        total++;
        if ({done_e, eq_e, gt_e, lt_e, cyc_e} !== 7'b1100_100) begin
            bad++;
            $display("FAIL busy_start_e got=%b want=1100100",
                     {done_e, eq_e, gt_e, lt_e, cyc_e});
        end
        total++;
        if ({done_f, eq_f, cyc_f} !== 5'b11_100) begin
            bad++;
            $display("FAIL busy_start_f got=%b want=11100", {done_f, eq_f, cyc_f});
        end
        en = 1'b0;
        step();
        total++;
        if ({eq_e, cyc_e} !== 4'b0_100) begin
            bad++;
            $display("FAIL en_low_idle got=%b want=0100", {eq_e, cyc_e});
        end
        en = 1'b1;
        step();
    endtask

    task automatic test_reset_back_to_back();
        start_cmp(16'h1234, 16'h1234, 1'b0);
        step(); step();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy_e, done_e, eq_e, gt_e, lt_e, cyc_e,
             busy_f, done_f, cyc_f} !== 13'h0) begin
            bad++;
            $display("FAIL async_rst got=%b want=0",
                     {busy_e, done_e, eq_e, gt_e, lt_e, cyc_e,
                      busy_f, done_f, cyc_f});
        end
        #1 rst = 1'b0;
        step();
        a = 16'h9000;
        b = 16'h1000;
        sm = 1'b0;
        start = 1'b1;
        step();
        total++;
        if (busy_e !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept1 busy got=%b want=1", busy_e);
        end
        a = 16'h1000;
        b = 16'h9000;
        step();
        total++;
        if ({busy_e, done_e, gt_e, lt_e, cyc_e} !== 7'b0110_001) begin
            bad++;
            $display("FAIL b2b_done1 got=%b want=0110001",
                     {busy_e, done_e, gt_e, lt_e, cyc_e});
        end
        step();
        start = 1'b0;
        total++;
        if ({busy_e, done_e, gt_e, lt_e, cyc_e} !== 7'b1000_000) begin
            bad++;
            $display("FAIL b2b_accept2 got=%b want=1000000",
                     {busy_e, done_e, gt_e, lt_e, cyc_e});
        end
        step();
        total++;
        if ({busy_e, done_e, gt_e, lt_e, cyc_e} !== 7'b0101_001) begin
            bad++;
            $display("FAIL b2b_done2 got=%b want=0101001",
                     {busy_e, done_e, gt_e, lt_e, cyc_e});
        end
        step(); step(); step(); step();
    endtask

    task automatic test_single_slice();
        start_cmp(16'h0003, 16'h0005, 1'b0);
        total++;
        if ({busy_s, done_s} !== 2'b10) begin
            bad++;
            $display("FAIL single_accept got=%b want=10", {busy_s, done_s});
        end
        step();
        total++;
        if ({busy_s, done_s, eq_s, gt_s, lt_s, cyc_s} !== 6'b01001_1) begin
            bad++;
            $display("FAIL single_u got=%b want=010011",
                     {busy_s, done_s, eq_s, gt_s, lt_s, cyc_s});
        end
        start_cmp(16'h0009, 16'h0001, 1'b1);
        step();
        total++;
        if ({done_s, eq_s, gt_s, lt_s} !== 4'b1001) begin
            bad++;
            $display("FAIL single_s got=%b want=1001", {done_s, eq_s, gt_s, lt_s});
        end
        start_cmp(16'h0009, 16'h0001, 1'b0);
        step();
        total++;
        if ({done_s, eq_s, gt_s, lt_s} !== 4'b1010) begin
            bad++;
            $display("FAIL single_u2 got=%b want=1010", {done_s, eq_s, gt_s, lt_s});
        end
        for (int i = 0; i < 5; i++) step();
    endtask

    initial begin
        test_reset();
        test_equal();
        test_early_exit();
        test_late_diff();
        test_abort_busy_start();
        test_reset_back_to_back();
        test_single_slice();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
